// File: rtl/seg_pkg.sv
// seg_pkg -- shared types, constants and glyph decoding for the 7-segment
// scan controller.
//
//   scan_state_e : scan FSM states (IDLE, DWELL, BLANK)
//   bcd_t        : one BCD digit
//   SEG_OFF      : active-low segment pattern with every segment dark
//   seg_decode() : BCD -> gfedcba active-low glyph; codes A-F are dark
//
// Optional build macro affecting users of this package: SEG_SCAN_LZB_EN
// (leading-zero blanking, handled in seg_scan_controller).

package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Standard glyphs, bit order gfedcba, 0 = segment lit.
  function automatic logic [6:0] seg_decode(input bcd_t value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_OFF;  // non-BCD codes: digit selected but dark
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer -- loadable down-counter used to time the dwell and blank
// phases of the scan controller.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset (count -> 0)
//   load        in   load load_value this cycle
//   load_value  in   WIDTH  value to load (phase length minus one)
//   count       out  WIDTH  current count
//   done        out  high while count is zero (last cycle of the phase)

module seg_scan_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign count = count_reg;
  assign done  = (count_reg == '0);

endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller -- time-multiplexes DIGITS BCD digits onto a shared
// active-low 7-segment bus with active-low per-digit selects. New frames are
// loaded through a valid/ready handshake into a load buffer and copied into
// the displayed (shadow) registers only at a frame boundary, so a frame is
// never shown half old / half new. A blank gap between digits suppresses
// ghosting.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   1 = scan, 0 = display dark
//   bcd_in       in   bcd_t [DIGITS-1:0] unpacked, digit 0 = rightmost
//   bcd_valid    in   bcd_in holds a new frame
//   bcd_ready    out  load buffer free; transfer on bcd_valid && bcd_ready
//   seg_out      out  7  gfedcba, active-low, registered
//   digit_sel    out  DIGITS one-cold, active-low, registered
//   frame_start  out  1-cycle pulse on the first drive cycle of digit 0
//
// Build macro: SEG_SCAN_LZB_EN -- when defined, leading zeros (from the top
// digit down to the first nonzero digit, never digit 0) are blanked. The mask
// is computed from the load buffer at commit time and held with the frame.

module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  bcd_t              bcd_in [DIGITS-1:0],
  input  logic              bcd_valid,
  output logic              bcd_ready,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] digit_sel,
  output logic              frame_start
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam bit               NO_GAP     = (BLANK_CYCLES == 0);

  // ---------------------------------------------------------------------
  // Scan sequencing
  // ---------------------------------------------------------------------
  scan_state_e      state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [6:0]       seg_reg;
  logic [DIGITS-1:0] sel_reg;
  logic             frame_start_reg;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_done;

  logic [IDX_W-1:0] idx_wrap;
  logic [IDX_W-1:0] entry_idx;
  logic             start_scan;
  logic             dwell_end;
  logic             blank_end;
  logic             enter_dwell;
  logic             enter_blank;
  logic             enter_dwell0;

  assign idx_wrap   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
  assign start_scan = (state_reg == IDLE);
  assign dwell_end  = (state_reg == DWELL) && tmr_done;
  assign blank_end  = (state_reg == BLANK) && tmr_done;

  // Phase transitions; a disabled controller never enters a scan phase.
  assign enter_dwell  = enable && (start_scan || blank_end || (dwell_end && NO_GAP));
  assign enter_blank  = enable && dwell_end && !NO_GAP;
  assign entry_idx    = start_scan ? '0 : idx_wrap;
  assign enter_dwell0 = enter_dwell && (entry_idx == '0);

  // The timer is reloaded on the same edge that changes phase, so each
  // phase begins with the counter at (length - 1) and ends when it hits 0.
  assign tmr_load  = enter_dwell || enter_blank;
  assign tmr_value = enter_blank ? BLANK_LOAD : DWELL_LOAD;

  seg_scan_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .count      (tmr_count),
    .done       (tmr_done)
  );

  // ---------------------------------------------------------------------
  // Frame buffering and handshake
  // ---------------------------------------------------------------------
  bcd_t load_buf_reg [DIGITS-1:0];
  bcd_t shadow_reg   [DIGITS-1:0];
  logic pending_reg;
  logic xfer;
  logic commit;

  assign bcd_ready = !pending_reg;
  assign xfer      = bcd_valid && bcd_ready;
  // A pending frame goes live at a frame boundary or whenever the scan is
  // idle, so a dark display never holds a stale frame back.
  assign commit    = pending_reg && (start_scan || enter_dwell0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
    end else if (xfer) begin
      pending_reg <= 1'b1;
    end else if (commit) begin
      pending_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      always_ff @(posedge clk) begin
        if (reset) begin
          load_buf_reg[gi] <= 4'hF;
          shadow_reg[gi]   <= 4'hF;
        end else begin
          if (xfer) begin
            load_buf_reg[gi] <= bcd_in[gi];
          end
          if (commit) begin
            shadow_reg[gi] <= load_buf_reg[gi];
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Leading-zero blanking
  // ---------------------------------------------------------------------
  logic digit_dark;

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] lzb_mask_reg;
  logic [DIGITS-1:0] lzb_mask_next;
  logic              lz_run;

  // Walk down from the top digit; the run of zeros ends at the first
  // nonzero digit. Digit 0 always stays visible so "0" still shows.
  always_comb begin
    lzb_mask_next = '0;
    lz_run        = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run           = lz_run && (load_buf_reg[i] == 4'h0);
      lzb_mask_next[i] = lz_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lzb_mask_reg <= '0;
    end else if (commit) begin
      lzb_mask_reg <= lzb_mask_next;
    end
  end

  assign digit_dark = lzb_mask_reg[idx_reg];
`else
  assign digit_dark = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Pin drive values for the current digit
  // ---------------------------------------------------------------------
  logic [6:0]        glyph;
  logic [DIGITS-1:0] sel_drive;

  assign glyph = digit_dark ? SEG_OFF : seg_decode(shadow_reg[idx_reg]);

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_sel
      assign sel_drive[gi] = (idx_reg != IDX_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Scan FSM with registered pin outputs. Pins reflect the state of the
  // previous cycle, except that dropping enable darkens them on the very
  // next edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      seg_reg         <= SEG_OFF;
      sel_reg         <= '1;
      frame_start_reg <= 1'b0;
    end else begin
      if (!enable) begin
        state_reg <= IDLE;
        idx_reg   <= '0;
      end else if (enter_dwell) begin
        state_reg <= DWELL;
        idx_reg   <= entry_idx;
      end else if (enter_blank) begin
        state_reg <= BLANK;
      end

      if (enable && (state_reg == DWELL)) begin
        seg_reg         <= glyph;
        sel_reg         <= sel_drive;
        // First dwell cycle of digit 0 is the only one with a full count.
        frame_start_reg <= (idx_reg == '0) && (tmr_count == DWELL_LOAD);
      end else begin
        seg_reg         <= SEG_OFF;
        sel_reg         <= '1;
        frame_start_reg <= 1'b0;
      end
    end
  end

  assign seg_out     = seg_reg;
  assign digit_sel   = sel_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller -- directed self-checking bench for
// seg_scan_controller with DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1
// (frame = 20 cycles: per digit 4 drive cycles then 1 dark cycle).
// Expectations for the leading-zero case follow SEG_SCAN_LZB_EN.

module tb_seg_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] bcd_in [3:0];
  logic       bcd_valid;
  logic       bcd_ready;
  logic [6:0] seg_out;
  logic [3:0] digit_sel;
  logic       frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .DIGITS       (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bcd_in      (bcd_in),
    .bcd_valid   (bcd_valid),
    .bcd_ready   (bcd_ready),
    .seg_out     (seg_out),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  // Hand-written glyph table, gfedcba active-low.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bcd(input logic [15:0] v);
    bcd_in[3] = v[15:12];
    bcd_in[2] = v[11:8];
    bcd_in[1] = v[7:4];
    bcd_in[0] = v[3:0];
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " seg"}, 32'(seg_out), 32'h7F);
    chk({tag, " sel"}, 32'(digit_sel), 32'hF);
    chk({tag, " fs"}, 32'(frame_start), 32'h0);
  endtask

  // Checks pin cycles k_from..k_to of a frame (k=0 is the frame_start cycle),
  // advancing one clock after each check. vals = {d3,d2,d1,d0}.
  task automatic chk_span(input string tag, input logic [15:0] vals, input int k_from, input int k_to);
    for (int k = k_from; k <= k_to; k++) begin
      int         d;
      int         pos;
      logic [3:0] exp_sel;
      logic [6:0] exp_seg;
      d   = k / 5;
      pos = k % 5;
      if (pos < 4) begin
        exp_sel = ~(4'b0001 << d);
        exp_seg = glyph(vals[d*4 +: 4]);
      end else begin
        exp_sel = 4'hF;
        exp_seg = 7'h7F;
      end
      chk($sformatf("%s k%0d sel", tag, k), 32'(digit_sel), 32'(exp_sel));
      chk($sformatf("%s k%0d seg", tag, k), 32'(seg_out), 32'(exp_seg));
      chk($sformatf("%s k%0d fs", tag, k), 32'(frame_start), (k == 0) ? 32'h1 : 32'h0);
      tick();
    end
  endtask

  initial begin
    logic [15:0] lzb_exp;

    // 1: reset held 3 cycles
    reset     = 1'b1;
    enable    = 1'b0;
    bcd_valid = 1'b0;
    set_bcd(16'h0000);
    tick(); tick(); tick();
    chk_dark("reset");
    chk("reset ready", 32'(bcd_ready), 32'h1);
    reset = 1'b0;

    // 2: load {1,2,3,4} while idle, then enable
    set_bcd(16'h1234);
    bcd_valid = 1'b1;
    chk("load1 ready pre", 32'(bcd_ready), 32'h1);
    tick();
    bcd_valid = 1'b0;
    set_bcd(16'h9999);
    chk("load1 ready busy", 32'(bcd_ready), 32'h0);
    enable = 1'b1;
    tick();
    chk("idle commit ready", 32'(bcd_ready), 32'h1);
    chk_dark("start gap");
    tick();
    chk_span("f1234", 16'h1234, 0, 19);

    // 3: load {5,5,5,5} during digit 1; commit at the next frame boundary
    chk_span("f1234b", 16'h1234, 0, 4);
    set_bcd(16'h5555);
    bcd_valid = 1'b1;
    chk("load2 ready pre", 32'(bcd_ready), 32'h1);
    chk_span("f1234b", 16'h1234, 5, 5);
    bcd_valid = 1'b0;
    set_bcd(16'h9999);
    chk("load2 ready busy", 32'(bcd_ready), 32'h0);
    chk_span("f1234b", 16'h1234, 6, 17);
    chk("load2 ready hold", 32'(bcd_ready), 32'h0);
    chk_span("f1234b", 16'h1234, 18, 18);
    chk("load2 ready after commit", 32'(bcd_ready), 32'h1);
    chk_span("f1234b", 16'h1234, 19, 19);
    chk_span("f5555", 16'h5555, 0, 19);

    // 4: disable mid-dwell of digit 2, then re-enable
    chk_span("f5555b", 16'h5555, 0, 11);
    enable = 1'b0;
    tick();
    chk_dark("disabled0");
    tick();
    chk_dark("disabled1");
    tick();
    chk_dark("disabled2");
    enable = 1'b1;
    tick();
    chk_dark("reenable gap");
    tick();
    chk_span("restart", 16'h5555, 0, 19);

    // 5: digit 0 = 4'hA is selected but dark; reset mid-frame drops pending load
    set_bcd(16'h555A);
    bcd_valid = 1'b1;
    chk_span("f5555c", 16'h5555, 0, 0);
    bcd_valid = 1'b0;
    chk_span("f5555c", 16'h5555, 1, 19);
    chk_span("f555A", 16'h555A, 0, 6);
    set_bcd(16'h9999);
    bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    chk("pending before reset", 32'(bcd_ready), 32'h0);
    reset = 1'b1;
    tick();
    chk_dark("midreset");
    chk("midreset ready", 32'(bcd_ready), 32'h1);
    reset = 1'b0;
    tick();
    chk_dark("post reset gap");
    tick();

    // 6: leading zeros {0,0,7,0}; shadow still holds reset value 4'hF
    set_bcd(16'h0070);
    bcd_valid = 1'b1;
    chk_span("fFFFF", 16'hFFFF, 0, 0);
    bcd_valid = 1'b0;
    chk_span("fFFFF", 16'hFFFF, 1, 19);
`ifdef SEG_SCAN_LZB_EN
    lzb_exp = 16'hFF70;
`else
    lzb_exp = 16'h0070;
`endif
    chk_span("f0070", lzb_exp, 0, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
